// File: rtl/ir_pkg.sv
// Shared constants and state encodings for the IR camera ping-pong frame buffer.
package ir_pkg;

  localparam int FRAME_W   = 32;
  localparam int FRAME_H   = 24;
  localparam int FRAME_PIX = FRAME_W * FRAME_H;
  localparam int CNT_FIRST = 5;
  localparam int CNT_LAST  = 1539;

  typedef enum logic [1:0] {
    B_EMPTY,
    B_FILL,
    B_FULL,
    B_READ
  } bank_st_e;

  typedef enum logic [1:0] {
    W_WAIT,
    W_RUN,
    W_DROP
  } wr_st_e;

endpackage

// File: rtl/ir_fb_bank.sv
// One frame bank: simple dual-port RAM, one write port, registered read port.
module ir_fb_bank #(
  parameter int DEPTH = 768,
  parameter int AW    = 10,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // No reset: contents and read register survive rst_n, which keeps this mappable to block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ir_frame_buf.sv
// Ping-pong frame buffer between the IR camera receiver and the NICE read port.
// Optional IRFB_STATS_EN adds frame_cnt, a wrapping count of frames promoted to READ.
module ir_frame_buf #(
  parameter int FRAME_PIX = ir_pkg::FRAME_PIX,
  parameter int CNT_FIRST = ir_pkg::CNT_FIRST,
  parameter int CNT_LAST  = ir_pkg::CNT_LAST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_data,
  input  logic        pix_vld,
  input  logic [15:0] pix_cnt,
  input  logic        rd_en,
  input  logic [9:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        frame_rdy,
  input  logic        frame_done,
  output logic [7:0]  ovf_cnt
`ifdef IRFB_STATS_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  import ir_pkg::*;

  logic [15:0] cnt_q;
  wr_st_e      st_q;
  bank_st_e    bank_q [2];
  logic        fill_b_q;
  logic        first_q;
  logic [9:0]  exp_q;
  logic        frame_rdy_q;
  logic [7:0]  ovf_q;
  logic        rd_zero_q;
  logic        rd_sel_q;
`ifdef IRFB_STATS_EN
  logic [15:0] frame_cnt_q;
`endif

  logic       strobe, hdr;
  logic [9:0] idx;
  logic       rel, rd_b, free0, free1, alloc_b;
  logic       promote, prom_b;
  logic       start, drop, restart, adv, bad, last_px;
  logic       wbank, we0, we1, rd_in_rng, re;
  logic [7:0] rdata0, rdata1;

  always_comb begin
    strobe  = pix_vld && (pix_cnt != cnt_q) && pix_cnt[0] &&
              (pix_cnt >= 16'(CNT_FIRST)) && (pix_cnt <= 16'(CNT_LAST));
    idx     = 10'((pix_cnt - 16'(CNT_FIRST)) >> 1);
    hdr     = strobe && (idx == '0);
    rel     = frame_done && frame_rdy_q;
    rd_b    = (bank_q[1] == B_READ);
    // A bank released this cycle is already free for an arriving header.
    free0   = (bank_q[0] == B_EMPTY) || (rel && !rd_b);
    free1   = (bank_q[1] == B_EMPTY) || (rel && rd_b);
    alloc_b = !free0;
    promote = (bank_q[0] != B_READ) && (bank_q[1] != B_READ) &&
              ((bank_q[0] == B_FULL) || (bank_q[1] == B_FULL));
    if ((bank_q[0] == B_FULL) && (bank_q[1] == B_FULL)) prom_b = first_q;
    else                                                prom_b = (bank_q[1] == B_FULL);
    start   = hdr && (st_q != W_RUN) && (free0 || free1);
    drop    = hdr && (st_q != W_RUN) && !(free0 || free1);
    restart = hdr && (st_q == W_RUN);
    adv     = strobe && (st_q == W_RUN) && (idx == exp_q);
    bad     = strobe && (st_q == W_RUN) && !hdr && (idx != exp_q);
    last_px = adv && (idx == 10'(FRAME_PIX - 1));
    wbank   = start ? alloc_b : fill_b_q;
    we0     = (start || restart || adv) && !wbank;
    we1     = (start || restart || adv) && wbank;
    rd_in_rng = (rd_addr < 10'(FRAME_PIX));
    re        = rd_en && rd_in_rng;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      st_q        <= W_WAIT;
      bank_q[0]   <= B_EMPTY;
      bank_q[1]   <= B_EMPTY;
      fill_b_q    <= 1'b0;
      first_q     <= 1'b0;
      exp_q       <= '0;
      frame_rdy_q <= 1'b0;
      ovf_q       <= '0;
      rd_zero_q   <= 1'b1;
      rd_sel_q    <= 1'b0;
`ifdef IRFB_STATS_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      cnt_q <= pix_cnt;
      if (rel) begin
        bank_q[rd_b] <= B_EMPTY;
        frame_rdy_q  <= 1'b0;
      end
      // Promotion looks at the current states, so a release always leaves one low cycle.
      if (promote) begin
        bank_q[prom_b] <= B_READ;
        frame_rdy_q    <= 1'b1;
`ifdef IRFB_STATS_EN
        frame_cnt_q    <= frame_cnt_q + 16'd1;
`endif
      end
      if (start) begin
        bank_q[alloc_b] <= B_FILL;
        fill_b_q        <= alloc_b;
        exp_q           <= 10'd1;
        st_q            <= W_RUN;
      end
      if (drop) begin
        st_q <= W_DROP;
        if (ovf_q != '1) ovf_q <= ovf_q + 8'd1;
      end
      if (restart) exp_q <= 10'd1;
      if (adv) begin
        exp_q <= exp_q + 10'd1;
        if (last_px) begin
          bank_q[fill_b_q] <= B_FULL;
          st_q             <= W_WAIT;
          if (bank_q[~fill_b_q] != B_FULL) first_q <= fill_b_q;
        end
      end
      if (bad) begin
        bank_q[fill_b_q] <= B_EMPTY;
        st_q             <= W_WAIT;
      end
      if (rd_en) begin
        rd_zero_q <= !frame_rdy_q || !rd_in_rng;
        rd_sel_q  <= rd_b;
      end
    end
  end

  ir_fb_bank #(.DEPTH(FRAME_PIX), .AW(10), .DW(8)) u_bank0 (
    .clk     (clk),
    .we_i    (we0),
    .waddr_i (idx),
    .wdata_i (pix_data),
    .re_i    (re),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  ir_fb_bank #(.DEPTH(FRAME_PIX), .AW(10), .DW(8)) u_bank1 (
    .clk     (clk),
    .we_i    (we1),
    .waddr_i (idx),
    .wdata_i (pix_data),
    .re_i    (re),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign rd_data   = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);
  assign frame_rdy = frame_rdy_q;
  assign ovf_cnt   = ovf_q;
`ifdef IRFB_STATS_EN
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_ir_frame_buf.sv
// Self-checking bench for ir_frame_buf: read-vector table plus hand-written frame sequences.
module tb_ir_frame_buf;

  localparam int CF = 5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pix_data;
  logic        pix_vld;
  logic [15:0] pix_cnt;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        frame_rdy;
  logic        frame_done;
  logic [7:0]  ovf_cnt;
`ifdef IRFB_STATS_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] sb_q [$];
  int         sb_addr_q [$];

  typedef struct {
    int addr;
    int expv;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  ir_frame_buf dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_vld    (pix_vld),
    .pix_cnt    (pix_cnt),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_rdy  (frame_rdy),
    .frame_done (frame_done),
    .ovf_cnt    (ovf_cnt)
`ifdef IRFB_STATS_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  function automatic logic [7:0] px(input int seed, input int i);
    return 8'((i + seed) & 255);
  endfunction

  task automatic send_range(input int seed, input int first, input int last);
    for (int c = CF + 2 * first; c <= CF + 2 * last; c++) begin
      pix_cnt  = 16'(c);
      pix_data = px(seed, (c - CF) / 2);
      tick();
    end
  endtask

  task automatic send_frame(input int seed);
    send_range(seed, 0, 767);
  endtask

  task automatic expect_rise(input string nm);
    chk({nm, " rdy low"}, int'(frame_rdy), 0);
    tick();
    chk({nm, " rdy high"}, int'(frame_rdy), 1);
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic rd(input int addr, input int expv, input string nm);
    logic [7:0] e;
    int a;
    rd_en   = 1'b1;
    rd_addr = 10'(addr);
    sb_q.push_back(8'(expv));
    sb_addr_q.push_back(addr);
    tick();
    rd_en = 1'b0;
    e = sb_q.pop_front();
    a = sb_addr_q.pop_front();
    chk($sformatf("%s addr %0d", nm, a), int'(rd_data), int'(e));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 0};
    tbl[1] = '{1, 1};
    tbl[2] = '{255, 255};
    tbl[3] = '{256, 0};
    tbl[4] = '{511, 255};
    tbl[5] = '{800, 0};
    tbl[6] = '{767, 255};

    rst_n = 1'b0; pix_data = '0; pix_vld = 1'b1; pix_cnt = '0;
    rd_en = 1'b0; rd_addr = '0; frame_done = 1'b0;
    tick(); tick(); tick();
    chk("reset frame_rdy", int'(frame_rdy), 0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset ovf_cnt", int'(ovf_cnt), 0);
    rst_n = 1'b1;
    tick();
    rd(5, 0, "read without frame");

    // Single frame
    send_frame(0);
    expect_rise("single");
    for (int i = 0; i < 7; i++) rd(tbl[i].addr, tbl[i].expv, $sformatf("tbl%0d", i));
    tick();
    chk("rd_data hold", int'(rd_data), 255);

    // Back-to-back: second frame waits FULL behind the READ bank
    send_frame(50);
    chk("b2b still rdy", int'(frame_rdy), 1);
    rd(10, 10, "b2b old frame");
    pulse_done();
    expect_rise("b2b next");
    rd(10, 60, "b2b frame2");
    rd(767, int'(px(50, 767)), "b2b frame2");

    // Overflow: both banks busy when the next header arrives
    send_frame(100);
    send_frame(150);
    chk("ovf count", int'(ovf_cnt), 1);
    rd(3, 53, "ovf intact");
    pulse_done();
    expect_rise("ovf promote");
    rd(400, int'(px(100, 400)), "ovf frame100");
    send_frame(200);
    pulse_done();
    expect_rise("fourth frame");
    rd(123, int'(px(200, 123)), "fourth frame");
    pulse_done();
    chk("released rdy", int'(frame_rdy), 0);
    tick();
    chk("released rdy stays", int'(frame_rdy), 0);
    pulse_done();
    chk("ignored done", int'(frame_rdy), 0);
    chk("ovf unchanged", int'(ovf_cnt), 1);

    // Header restart mid-frame
    send_range(7, 0, 299);
    send_frame(9);
    expect_rise("restart");
    rd(299, int'(px(9, 299)), "restart");
    rd(0, 9, "restart");
    pulse_done();

    // Skipped index discards the partial frame
    send_range(3, 0, 10);
    send_range(3, 12, 767);
    tick(); tick();
    chk("skip no frame", int'(frame_rdy), 0);
    chk("skip not ovf", int'(ovf_cnt), 1);
    send_frame(11);
    expect_rise("after skip");
    rd(700, int'(px(11, 700)), "after skip");

    // Reset in the middle of a fill
    send_range(13, 0, 400);
    rst_n = 1'b0;
    tick();
    chk("midreset rdy", int'(frame_rdy), 0);
    chk("midreset ovf", int'(ovf_cnt), 0);
    chk("midreset rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    tick();
    rd(5, 0, "post reset no frame");
    send_frame(17);
    expect_rise("post reset");
    rd(511, int'(px(17, 511)), "post reset");

    // frame_done coincides with the last pixel of the next frame
    send_range(19, 0, 766);
    pix_cnt    = 16'(CF + 2 * 767);
    pix_data   = px(19, 767);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    expect_rise("done+last");
    rd(767, int'(px(19, 767)), "done+last");
    rd(100, int'(px(19, 100)), "done+last");

    // Header coincides with frame_done while both banks are busy
    send_frame(21);
    pix_cnt    = 16'(CF);
    pix_data   = px(23, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    expect_rise("done+hdr");
    chk("done+hdr no ovf", int'(ovf_cnt), 0);
    send_range(23, 1, 767);
    rd(42, int'(px(21, 42)), "done+hdr older");
    pulse_done();
    expect_rise("done+hdr newer");
    rd(42, int'(px(23, 42)), "done+hdr newer");
    rd(0, int'(px(23, 0)), "done+hdr newer");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
